// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round scheduler: default round count,
// round-index width, FSM state encoding and the 128-bit block type.
package aes_pkg;

    localparam int NR_DEF = 10;
    localparam int RW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [127:0] block_t;

endpackage

// File: rtl/aes_round_cnt.sv
// Round counter for the AES scheduler. Loads 1 when a block is accepted,
// steps once per round, saturates at NR and raises a registered terminal
// flag while the count equals NR. Clear returns the counter to 0.
module aes_round_cnt
    import aes_pkg::*;
#(
    parameter int NR = NR_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          inc,
    output logic [RW-1:0] count,
    output logic          last
);

    // Count and terminal flag advance together so last never lags count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            last  <= 1'b0;
        end else if (load) begin
            count <= RW'(1);
            last  <= (NR == 1);
        end else if (inc && !last) begin
            count <= count + RW'(1);
            last  <= ((count + RW'(1)) == RW'(NR));
        end
    end

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES-128 round scheduler. Holds the cipher state and the previous
// round key, feeds them to an external combinational round datapath and
// writes back its result once per clock until NR rounds are done.
// Optional feature: define AES_SCHED_ABORT_EN to add the abort input, which
// cancels an in-flight block without producing a result.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NR = NR_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
`ifdef AES_SCHED_ABORT_EN
    input  logic          abort,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  plain_text,
    input  logic [127:0]  key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  cipher_text,
    output logic [127:0]  dp_state_in,
    output logic [127:0]  dp_key_in,
    output logic [RW-1:0] dp_round,
    output logic          dp_final,
    input  logic [127:0]  dp_state_out,
    input  logic [127:0]  dp_key_out,
    output logic          busy
);

    state_t state;
    block_t state_reg;
    block_t key_reg;
    logic   accept;
    logic   abort_hit;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   round_last;

    // Handshake and counter control derived from the current state.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        accept  = in_valid && in_ready;
`ifdef AES_SCHED_ABORT_EN
        abort_hit = abort && (state != ST_IDLE);
`else
        abort_hit = 1'b0;
`endif
        cnt_inc = (state == ST_ROUND);
        cnt_clr = ((state == ST_ROUND) && round_last) || abort_hit;
    end

    aes_round_cnt #(
        .NR (NR),
        .RW (RW)
    ) u_round_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load  (accept),
        .inc   (cnt_inc),
        .count (dp_round),
        .last  (round_last)
    );

    // Main FSM: state, datapath registers and all handshake outputs.
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || abort_hit) begin
            state       <= ST_IDLE;
            state_reg   <= '0;
            key_reg     <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            cipher_text <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= plain_text ^ key;
                        key_reg   <= key;
                        state     <= ST_ROUND;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    state_reg <= dp_state_out;
                    key_reg   <= dp_key_out;
                    if (round_last) begin
                        state       <= ST_DONE;
                        out_valid   <= 1'b1;
                        cipher_text <= dp_state_out;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state       <= ST_IDLE;
                        out_valid   <= 1'b0;
                        cipher_text <= '0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign dp_state_in = state_reg;
    assign dp_key_in   = key_reg;
    assign dp_final    = round_last;

endmodule

// File: tb/tb_aes_round_sched.sv
// Testbench for aes_round_sched. A behavioural AES-128 round datapath is
// attached to the dp_* ports; expected ciphertexts are published test vectors.
// A scoreboard queue holds expected results; a negedge monitor pops and
// compares on every output handshake. Build with +define+AES_SCHED_ABORT_EN
// to include the abort scenarios.
module tb_aes_round_sched;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] X_C1  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P_S   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C_S   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] C_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cipher_text;
    logic [127:0] dp_state_in;
    logic [127:0] dp_key_in;
    logic [3:0]   dp_round;
    logic         dp_final;
    logic [127:0] dp_state_out;
    logic [127:0] dp_key_out;
    logic         busy;
`ifdef AES_SCHED_ABORT_EN
    logic         abort;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [127:0] sb[$];
    int out_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_sched dut (
        .clk          (clk),
        .rst          (rst),
`ifdef AES_SCHED_ABORT_EN
        .abort        (abort),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .plain_text   (plain_text),
        .key          (key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cipher_text  (cipher_text),
        .dp_state_in  (dp_state_in),
        .dp_key_in    (dp_key_in),
        .dp_round     (dp_round),
        .dp_final     (dp_final),
        .dp_state_out (dp_state_out),
        .dp_key_out   (dp_key_out),
        .busy         (busy)
    );

    // ---------------- reference AES round datapath ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        if (x == 8'h00) r = 8'h00;
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic fin);
        logic [7:0]   a[16];
        logic [7:0]   b[16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = a[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
                b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ rk;
    endfunction

    always_comb begin
        dp_key_out   = round_key(dp_key_in, int'(dp_round));
        dp_state_out = enc_round(dp_state_in, dp_key_out, dp_final);
    end

    // ---------------- checking infrastructure ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake pops one expected ciphertext.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %h expected none", cipher_text);
            end else begin
                check("cipher_text", cipher_text, sb.pop_front());
            end
            out_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [127:0] pt, input logic [127:0] k);
        plain_text = pt;
        key        = k;
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        while (!out_valid && n < limit) begin
            step();
            n++;
        end
        check(name, out_valid, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        plain_text = '0;
        key        = '0;
`ifdef AES_SCHED_ABORT_EN
        abort      = 1'b0;
`endif
        repeat (3) step();
        check("rst_in_ready",  in_ready,    1'b1);
        check("rst_out_valid", out_valid,   1'b0);
        check("rst_busy",      busy,        1'b0);
        check("rst_cipher",    cipher_text, '0);
        check("rst_dp_round",  dp_round,    '0);
        check("rst_dp_final",  dp_final,    1'b0);
        check("rst_dp_state",  dp_state_in, '0);
        check("rst_dp_key",    dp_key_in,   '0);
        rst = 1'b0;
        step();

        // FIPS-197 C.1 with exact latency and post-result IDLE.
        sb.push_back(C_C1);
        offer(P_C1, K_C1);
        check("c1_state_after_accept", dp_state_in, X_C1);
        check("c1_key_after_accept",   dp_key_in,   K_C1);
        check("c1_round_after_accept", dp_round,    4'd1);
        check("c1_busy",               busy,        1'b1);
        check("c1_in_ready_busy",      in_ready,    1'b0);
        repeat (9) step();
        check("c1_round_nr",     dp_round,  4'd10);
        check("c1_final_nr",     dp_final,  1'b1);
        check("c1_valid_early",  out_valid, 1'b0);
        step();
        check("c1_valid_latency", out_valid, 1'b1);
        check("c1_done_round",    dp_round,  4'd0);
        check("c1_done_final",    dp_final,  1'b0);
        step();
        check("c1_idle_in_ready",  in_ready,    1'b1);
        check("c1_idle_out_valid", out_valid,   1'b0);
        check("c1_idle_cipher",    cipher_text, '0);

        // Backpressure in DONE.
        out_ready = 1'b0;
        sb.push_back(C_B);
        offer(P_B, K_B);
        wait_valid("bp_valid", 20);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid",  out_valid,   1'b1);
            check("bp_hold_cipher", cipher_text, C_B);
            check("bp_hold_ready",  in_ready,    1'b0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_ready", in_ready,  1'b1);
        check("bp_release_valid", out_valid, 1'b0);

        // in_valid while busy is ignored.
        sb.push_back(C_Z);
        offer('0, '0);
        repeat (2) step();
        check("busy_round3", dp_round, 4'd3);
        check("busy_in_ready3", in_ready, 1'b0);
        offer(P_B, K_B);
        repeat (3) step();
        check("busy_round7", dp_round, 4'd7);
        offer(P_C1, K_C1);
        wait_valid("busy_valid", 20);
        step();
        repeat (14) step();
        check("busy_no_second", out_valid, 1'b0);
        check("busy_idle", in_ready, 1'b1);

        // Reset in the middle of ROUND.
        offer(P_B, K_B);
        repeat (4) step();
        check("mid_round5", dp_round, 4'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_in_ready",  in_ready,    1'b1);
        check("mid_round",     dp_round,    4'd0);
        check("mid_out_valid", out_valid,   1'b0);
        check("mid_busy",      busy,        1'b0);
        check("mid_state",     dp_state_in, '0);
        check("mid_key",       dp_key_in,   '0);
        sb.push_back(C_S);
        offer(P_S, K_B);
        wait_valid("mid_valid", 20);
        step();

        // Back-to-back with in_valid and out_ready held high.
        out_cyc.delete();
        in_valid = 1'b1;
        for (int v = 0; v < 3; v++) begin
            int guard;
            case (v)
                0:       begin plain_text = P_C1; key = K_C1; sb.push_back(C_C1); end
                1:       begin plain_text = P_B;  key = K_B;  sb.push_back(C_B);  end
                default: begin plain_text = P_S;  key = K_B;  sb.push_back(C_S);  end
            endcase
            guard = 0;
            while (!in_ready && guard < 30) begin
                step();
                guard++;
            end
            step();
        end
        in_valid = 1'b0;
        for (int g = 0; g < 40 && out_cyc.size() < 3; g++) step();
        check("b2b_count", out_cyc.size(), 3);
        if (out_cyc.size() == 3) begin
            check("b2b_gap1", out_cyc[1] - out_cyc[0], 12);
            check("b2b_gap2", out_cyc[2] - out_cyc[1], 12);
        end
        step();

`ifdef AES_SCHED_ABORT_EN
        // Abort at round 4: no result, back to IDLE.
        begin
            logic seen;
            offer(P_B, K_B);
            repeat (3) step();
            check("ab_round4", dp_round, 4'd4);
            abort = 1'b1;
            step();
            abort = 1'b0;
            check("ab_in_ready", in_ready,    1'b1);
            check("ab_busy",     busy,        1'b0);
            check("ab_round",    dp_round,    4'd0);
            check("ab_state",    dp_state_in, '0);
            check("ab_key",      dp_key_in,   '0);
            seen = out_valid;
            repeat (14) begin
                step();
                seen = seen | out_valid;
            end
            check("ab_no_valid", seen, 1'b0);
        end
        // Abort together with accept in IDLE: accept wins.
        abort = 1'b1;
        sb.push_back(C_S);
        offer(P_S, K_B);
        abort = 1'b0;
        check("ab_idle_accept_busy",  busy,     1'b1);
        check("ab_idle_accept_round", dp_round, 4'd1);
        wait_valid("ab_idle_valid", 20);
        step();
`endif

        repeat (5) step();
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
